// File: rtl/core_v2_pkg.sv
// core_v2_pkg: opcodes, func codes, FSM/ALU enums and fault codes shared by the core_v2 files.
package core_v2_pkg;
  localparam logic [5:0] OP_ALU = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_ADDI = 6'd8, OP_LW = 6'd32, OP_SW = 6'd40;
  localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_AND = 6'd36, FN_OR = 6'd37, FN_XOR = 6'd38, FN_SLT = 6'd42;
  localparam logic [1:0] FAULT_NONE = 2'd0, FAULT_ILLEGAL = 2'd1, FAULT_TIMEOUT = 2'd2;
  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_e;
  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_J || op == OP_BEQ || op == OP_ADDI || op == OP_LW || op == OP_SW ||
           (op == OP_ALU && (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                             fn == FN_OR || fn == FN_XOR || fn == FN_SLT));
  endfunction
  // Only register-register ops select by func; everything else adds (ADDI, LW/SW address).
  function automatic alu_op_e alu_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op != OP_ALU) return ALU_ADD;
    if (fn == FN_SUB) return ALU_SUB;
    if (fn == FN_AND) return ALU_AND;
    if (fn == FN_OR) return ALU_OR;
    if (fn == FN_XOR) return ALU_XOR;
    if (fn == FN_SLT) return ALU_SLT;
    return ALU_ADD;
  endfunction
endpackage

// File: rtl/core_v2_regfile.sv
// core_v2_regfile: two async read ports, one sync write port, register 0 hardwired to zero.
module core_v2_regfile #(
  parameter int NREGS = 8,
  parameter int DATA_W = 8,
  localparam int IW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     ra1_i,
  input  logic [IW-1:0]     ra2_i,
  input  logic              we_i,
  input  logic [IW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);
  logic [DATA_W-1:0] rf_q [NREGS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    else if (we_i && wa_i != '0) rf_q[wa_i] <= wd_i;
  end
  assign rd1_o = ra1_i == '0 ? '0 : rf_q[ra1_i];
  assign rd2_o = ra2_i == '0 ? '0 : rf_q[ra2_i];
endmodule

// File: rtl/core_v2.sv
// core_v2: multi-cycle MIPS-subset core on the grant-request bus.
// Defining CORE_BUS_TIMEOUT_EN enables the bus-timeout watchdog (fault 2).
module core_v2 import core_v2_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_given,
  output logic              grant_request,
  output logic              rw,
  output logic [ADDR_W:0]   address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              halted,
  output logic [1:0]        fault
);
  localparam int NB = 32 / DATA_W;
  localparam int IW = $clog2(NREGS);
  localparam int AW1 = ADDR_W + 1;
  state_e st_q, st_d;
  alu_op_e aop_q, aop_d;
  logic [ADDR_W-1:0] pc_q, pc_d, br_off, ia;
  logic [31:0] ir_q, ir_d;
  logic [1:0] beat_q, beat_d, fault_q, fault_d;
  logic req_q, req_d, halt_q, halt_d, gnt, we;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm, alu_y, wd, rd1, rd2;
  logic [ADDR_W:0] ea_q, ea_d;
  logic [5:0] opcode, fn;
  logic [IW-1:0] rs, rt, rd, wa;
  logic unused_ir;
  assign opcode = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign rs = ir_q[21 +: IW];
  assign rt = ir_q[16 +: IW];
  assign rd = ir_q[11 +: IW];
  assign imm = DATA_W'(signed'(ir_q[15:0]));
  assign br_off = ADDR_W'(signed'(ir_q[15:0]));
  assign ia = pc_q - ADDR_W'(NB);
  assign gnt = req_q && grant_given;
  assign unused_ir = ^ir_q;
  assign alu_y = aop_q == ALU_SUB ? a_q - b_q :
                 aop_q == ALU_AND ? a_q & b_q :
                 aop_q == ALU_OR  ? a_q | b_q :
                 aop_q == ALU_XOR ? a_q ^ b_q :
                 aop_q == ALU_SLT ? DATA_W'($signed(a_q) < $signed(b_q)) : a_q + b_q;
  core_v2_regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst_n(reset), .ra1_i(rs), .ra2_i(rt),
    .we_i(we), .wa_i(wa), .wd_i(wd), .rd1_o(rd1), .rd2_o(rd2)
  );
`ifdef CORE_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT == 0;
`endif
  always_comb begin
    st_d = st_q;
    aop_d = aop_q;
    pc_d = pc_q;
    ir_d = ir_q;
    beat_d = beat_q;
    req_d = req_q;
    a_d = a_q;
    b_d = b_q;
    ea_d = ea_q;
    halt_d = halt_q;
    fault_d = fault_q;
    we = 1'b0;
    wa = rt;
    wd = alu_y;
    // The grant cycle always drops the request, giving the mandatory 1-cycle gap.
    if ((st_q == ST_FETCH || st_q == ST_MEM) && !req_q) req_d = 1'b1;
    if (gnt) req_d = 1'b0;
    case (st_q)
      ST_FETCH: if (gnt) begin
        ir_d = (ir_q << DATA_W) | 32'(data_in);
        pc_d = pc_q + 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(NB - 1)) begin
          beat_d = '0;
          st_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rd1;
        b_d = (opcode == OP_ALU || opcode == OP_BEQ) ? rd2 : imm;
        aop_d = alu_decode(opcode, fn);
        st_d = ST_EXEC;
        if (!op_legal(opcode, fn)) begin
          st_d = ST_HALT;
          halt_d = 1'b1;
          fault_d = FAULT_ILLEGAL;
        end
      end
      ST_EXEC: begin
        st_d = ST_FETCH;
        if (opcode == OP_ALU || opcode == OP_ADDI) begin
          we = 1'b1;
          wa = opcode == OP_ALU ? rd : rt;
        end else if (opcode == OP_J) pc_d = ir_q[ADDR_W-1:0];
        else if (opcode == OP_BEQ) pc_d = a_q == b_q ? ia + br_off : pc_q;
        else begin
          ea_d = AW1'(alu_y);
          st_d = ST_MEM;
        end
      end
      ST_MEM: if (gnt) begin
        st_d = ST_FETCH;
        we = opcode == OP_LW;
        wd = data_in;
      end
      default: ;
    endcase
`ifdef CORE_BUS_TIMEOUT_EN
    tmo_d = (gnt || !req_q) ? '0 : tmo_q + 1'b1;
    if (req_q && !grant_given && tmo_q == TW'(TIMEOUT - 1)) begin
      req_d = 1'b0;
      st_d = ST_HALT;
      halt_d = 1'b1;
      fault_d = FAULT_TIMEOUT;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= ST_FETCH;
      aop_q <= ALU_ADD;
      pc_q <= ADDR_W'(RESET_PC);
      ir_q <= '0;
      beat_q <= '0;
      req_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ea_q <= '0;
      halt_q <= 1'b0;
      fault_q <= FAULT_NONE;
`ifdef CORE_BUS_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      aop_q <= aop_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      beat_q <= beat_d;
      req_q <= req_d;
      a_q <= a_d;
      b_q <= b_d;
      ea_q <= ea_d;
      halt_q <= halt_d;
      fault_q <= fault_d;
`ifdef CORE_BUS_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  // Outputs derive only from registered state, so they hold steady while a request is pending.
  assign grant_request = req_q;
  assign address = !req_q ? '0 : st_q == ST_MEM ? ea_q : {1'b0, pc_q};
  assign rw = req_q && st_q == ST_MEM && opcode == OP_SW;
  assign data_out = rw ? rd2 : '0;
  assign halted = halt_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_core_v2.sv
// tb_core_v2: directed-vector bench for core_v2 (DATA_W=16, RESET_PC=2, TIMEOUT=4).
module tb_core_v2;
  localparam int DW = 16, AW = 8;
  logic clk = 0, reset = 0, grant_given = 0, grant_request, rw, halted;
  logic [AW:0] address;
  logic [DW-1:0] data_in = '0, data_out;
  logic [1:0] fault;
  core_v2 #(.DATA_W(DW), .ADDR_W(AW), .NREGS(8), .RESET_PC(2), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .grant_given(grant_given), .grant_request(grant_request),
    .rw(rw), .address(address), .data_in(data_in), .data_out(data_out),
    .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [DW-1:0] mem [512];
  bit gnt_en = 1, idle_gg = 0, prev_req = 0;
  int rise_cyc[$], rise_addr[$], rd_addr[$];
  logic [AW:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  logic [AW:0] h_a;
  logic h_rw;
  logic [DW-1:0] h_d;
  int stab_err = 0, n_chk = 0, n_pass = 0, rel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory/GPIO responder: grants immediately, GPIO reads return 0xBEEF and GPIO writes are not stored.
  initial forever begin
    @(negedge clk);
    if (grant_request && !prev_req) begin
      rise_cyc.push_back(cyc);
      rise_addr.push_back(int'(address));
      h_a = address;
      h_rw = rw;
      h_d = data_out;
    end else if (grant_request && (address !== h_a || rw !== h_rw || data_out !== h_d)) stab_err++;
    prev_req = grant_request;
    grant_given = (grant_request && gnt_en) || idle_gg;
    data_in = address[AW] ? 16'hBEEF : mem[address];
    if (grant_request && gnt_en) begin
      if (rw) begin
        wr_a.push_back(address);
        wr_d.push_back(data_out);
        if (!address[AW]) mem[address] = data_out;
      end else rd_addr.push_back(int'(address));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ityp(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] rtyp(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  task automatic put(input int a, input logic [31:0] ins);
    mem[a] = ins[31:16];
    mem[a+1] = ins[15:0];
  endtask
  task automatic clear_logs();
    rise_cyc.delete(); rise_addr.delete(); rd_addr.delete(); wr_a.delete(); wr_d.delete();
  endtask
  task automatic do_reset();
    @(negedge clk); #1 reset = 0;
    @(negedge clk); #1 clear_logs();
    reset = 1;
    rel = cyc;
  endtask
  task automatic wait_halt(input int budget);
    for (int n = 0; n < budget && !halted; n++) @(negedge clk);
    chk("halt_wait", halted, 1);
  endtask
  task automatic wait_rises(input int k, input int budget);
    for (int n = 0; n < budget && rise_cyc.size() < k; n++) @(negedge clk);
    chk("rise_wait", rise_cyc.size() >= k, 1);
  endtask
  function automatic int rc(input int i);
    return i < rise_cyc.size() ? rise_cyc[i] : -1000;
  endfunction
  function automatic int ra(input int i);
    return i < rise_addr.size() ? rise_addr[i] : -1;
  endfunction
  function automatic int rda(input int i);
    return i < rd_addr.size() ? rd_addr[i] : -1;
  endfunction

  logic [AW:0] exp_a [8] = '{9'h040, 9'h105, 9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h047};
  logic [DW-1:0] exp_d [8] = '{16'h0002, 16'h1234, 16'hBEEF, 16'h0001, 16'h4110, 16'h1224, 16'h0000, 16'hD123};

  initial begin
    int n, cnt;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    #1;
    chk("rst_req", grant_request, 0);
    chk("rst_rw", rw, 0);
    chk("rst_addr", address, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    // Program A: ALU ops, loads/stores incl. GPIO, r0 discard, jump, illegal opcode.
    put(2, ityp(8, 0, 1, 5));
    put(4, ityp(8, 0, 2, 3));
    put(6, rtyp(34, 3, 1, 2));
    put(8, ityp(40, 0, 3, 'h40));
    put(10, ityp(8, 0, 1, 'h1234));
    put(12, ityp(40, 0, 1, 'h105));
    put(14, ityp(32, 0, 4, 'h105));
    put(16, ityp(40, 0, 4, 'h41));
    put(18, ityp(8, 0, 6, -1));
    put(20, rtyp(42, 5, 6, 3));
    put(22, rtyp(38, 7, 6, 4));
    put(24, ityp(40, 0, 5, 'h42));
    put(26, ityp(40, 0, 7, 'h43));
    put(28, rtyp(36, 5, 4, 1));
    put(30, ityp(40, 0, 5, 'h44));
    put(32, ityp(8, 0, 0, 7));
    put(34, ityp(40, 0, 0, 'h45));
    put(36, {6'd2, 26'd40});
    put(38, ityp(40, 0, 1, 'h46));
    put(40, rtyp(32, 3, 4, 1));
    put(42, ityp(40, 2, 3, 'h44));
    put(44, ityp(63, 0, 0, 0));
    do_reset();
    wait_halt(600);
    chk("first_req_delay", rc(0) - rel, 1);
    chk("reset_pc", ra(0), 2);
    chk("sub_fetch_addr", ra(4), 6);
    chk("sub_latency", rc(6) - rc(4), 6);
    chk("sw_latency", rc(9) - rc(6), 8);
    chk("sw_mem_addr", ra(8), 'h40);
    chk("wr_count", wr_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_addr%0d", i), i < wr_a.size() ? wr_a[i] : 'x, exp_a[i]);
      chk($sformatf("wr_data%0d", i), i < wr_d.size() ? wr_d[i] : 'x, exp_d[i]);
    end
    chk("illegal_fault", fault, 1);
    chk("illegal_halted", halted, 1);
    n = rise_cyc.size();
    repeat (20) @(negedge clk);
    chk("halt_no_req", rise_cyc.size(), n);
    chk("halt_req_low", grant_request, 0);
    @(negedge clk); #1 reset = 0;
    #1;
    chk("halt_rst_fault", fault, 0);
    chk("halt_rst_halted", halted, 0);
    @(negedge clk); #1 clear_logs();
    reset = 1;
    rel = cyc;
    wait_rises(1, 10);
    chk("restart_pc", ra(0), 2);
    chk("restart_delay", rc(0) - rel, 1);
    // Program B: BEQ not taken then taken, with grant_given held high even when idle.
    for (int i = 0; i < 512; i++) mem[i] = '0;
    put(2, ityp(8, 0, 1, 1));
    put(4, ityp(8, 0, 2, 2));
    put(6, ityp(4, 1, 2, 10));
    put(8, ityp(4, 1, 1, -4));
    idle_gg = 1;
    do_reset();
    wait_rises(15, 300);
    chk("beq_not_taken", rda(6), 8);
    chk("beq_taken", rda(8), 4);
    chk("beq_loop", rda(14), 4);
    chk("beq_nt_latency", rc(6) - rc(4), 6);
    chk("beq_t_latency", rc(8) - rc(6), 6);
    idle_gg = 0;
    // Unanswered request.
    gnt_en = 0;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_request) cnt++;
    end
`ifdef CORE_BUS_TIMEOUT_EN
    chk("timeout_req_cycles", cnt, 4);
    chk("timeout_fault", fault, 2);
    chk("timeout_halted", halted, 1);
`else
    chk("wait_req_cycles", cnt, 100);
    chk("wait_fault", fault, 0);
    chk("wait_halted", halted, 0);
`endif
    chk("req_stable", stab_err, 0);
    @(negedge clk); #1 reset = 0;
    #1;
    chk("rst_drops_req", grant_request, 0);
    reset = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
